mcpu_core_tlb_arb: RTL and testbench
====================================

// Module: mcpu_core_tlb_arb
// PURPOSE
//  Shares the single core TLB lookup port between the instruction-fetch requester (I) and the
//  data TLB stage (D). Issues one lookup per cycle and tracks up to MAX_OUTST in-flight lookups
//  in an owner FIFO. Routes each in-order TLB response back to its owner. Drops responses
//  belonging to lookups killed by pipe_flush.
// PARAMETERS
//  MAX_OUTST    2  max lookups issued but not yet answered (1..4)
//  STARVE_LIMIT 4  consecutive D grants while I waits before I is forced a grant (1..15)
// PORTS
//  clkrst_core_clk    in   1   core clock
//  clkrst_core_rst    in   1   synchronous active-high reset
//  pipe_flush         in   1   kill all in-flight lookups; block issue this cycle
//  user_mode          in   1   privilege of current lookups, forwarded as tlb_user
//  i_req_valid        in   1   fetch lookup request
//  i_req_vpn          in   20  fetch virtual page [31:12]
//  i_req_ready        out  1   fetch request accepted this cycle
//  d_req_valid        in   1   data lookup request
//  d_req_vpn          in   20  data virtual page [31:12]
//  d_req_is_write     in   1   data lookup is a store
//  d_req_ready        out  1   data request accepted this cycle
//  tlb_re             out  1   lookup strobe
//  tlb_addr           out  20  lookup vpn
//  tlb_is_write       out  1   store permission check (0 for I)
//  tlb_is_exec        out  1   execute permission check (1 for I)
//  tlb_user           out  1   = user_mode
//  tlb_accept         in   1   TLB takes the lookup when tlb_re & tlb_accept
//  tlb_rsp_valid      in   1   in-order lookup result valid
//  tlb_phys_addr      in   20  physical page
//  tlb_flags          in   4   permission/fault flags
//  i_rsp_valid        out  1   result for fetch
//  d_rsp_valid        out  1   result for data
//  rsp_phys_addr      out  20  = tlb_phys_addr (shared)
//  rsp_flags          out  4   = tlb_flags (shared)
//  err_unexp_rsp      out  1   sticky: tlb_rsp_valid seen with empty owner FIFO
// BEHAVIOUR
//  - Reset: owner FIFO empty, starve_cnt=0, err_unexp_rsp=0. All outputs 0 while reset is high.
//  - Issue is combinational, zero latency. can_issue = ~full & ~pipe_flush & tlb_accept.
//    full uses the pre-pop count; a same-cycle pop does not free a slot.
//  - Grant: D wins by default. I wins when only I requests, or when starve_cnt==STARVE_LIMIT.
//  - starve_cnt: +1 on a D grant while i_req_valid. Clears on an I grant or when ~i_req_valid.
//    Saturates at STARVE_LIMIT.
//  - On a grant: tlb_re=1, the winner's ready=1, loser's ready=0. Push {owner, kill=0} to the FIFO.
//    Both readies are 0 when can_issue=0.
//  - Response: tlb_rsp_valid pops the FIFO head. The matching *_rsp_valid is asserted the same
//    cycle, only if head.kill==0 and ~pipe_flush. Push and pop may coincide; count stays unchanged.
//  - pipe_flush: sets kill on every FIFO entry. A response arriving in the flush cycle still
//    pops but is suppressed.
//  - Empty FIFO with tlb_rsp_valid: no pop, no rsp, err_unexp_rsp<=1 until reset.
//  - Reset mid-operation discards all entries; the TLB shares the same reset.
// STRUCTURE
//  - Shared package mcpu_core_tlb_pkg: OWNER_I=1'b0, OWNER_D=1'b1, VPN_W=20, FLAGS_W=4.
//  - Sub-module mcpu_core_tlb_owner_fifo (MAX_OUTST entries of {owner,kill}):
//    push/pop/kill_all ports; full, empty and head outputs.
//  - Top level holds the grant logic, the starve counter and response routing.
// TESTING
//  1. Only I: i_req_vpn=20'h00400, tlb_accept=1 -> tlb_re, tlb_is_exec=1, i_req_ready same cycle.
//     Rsp phys 20'h12345 two cycles later -> i_rsp_valid=1, rsp_phys_addr=20'h12345.
//  2. I and D always valid, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//  3. MAX_OUTST=2, two D grants, no rsp -> d_req_ready=0 in cycle 3.
//     Rsp plus new req in the same cycle -> req not accepted; accepted the next cycle.
//  4. Issue I then D, pipe_flush, then two responses -> FIFO drains, no i/d_rsp_valid.
//     A D request in the flush cycle -> d_req_ready=0.
//  5. tlb_rsp_valid with FIFO empty -> err_unexp_rsp=1 and held. Reset -> 0.
//  6. Reset asserted with 2 in flight -> after reset, FIFO empty and new I request granted at once.

Source files
------------

// File: rtl/mcpu_core_tlb_pkg.sv
// mcpu_core_tlb_pkg: shared owner encoding, widths and owner-FIFO entry type for the core TLB arbiter
package mcpu_core_tlb_pkg;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam int VPN_W = 20;
  localparam int FLAGS_W = 4;
  typedef struct packed {
    logic owner;
    logic kill;
  } owner_ent_t;
endpackage

// File: rtl/mcpu_core_tlb_arb_if.sv
// mcpu_core_tlb_arb_if: I/D request, TLB lookup and response bus; slave = arbiter, master = requesters + TLB
interface mcpu_core_tlb_arb_if;
  import mcpu_core_tlb_pkg::*;
  logic pipe_flush, user_mode;
  logic i_req_valid, i_req_ready, d_req_valid, d_req_is_write, d_req_ready;
  logic tlb_re, tlb_is_write, tlb_is_exec, tlb_user, tlb_accept, tlb_rsp_valid;
  logic i_rsp_valid, d_rsp_valid, err_unexp_rsp;
  logic [VPN_W-1:0] i_req_vpn, d_req_vpn, tlb_addr, tlb_phys_addr, rsp_phys_addr;
  logic [FLAGS_W-1:0] tlb_flags, rsp_flags;
  modport slave (
    input pipe_flush, user_mode, i_req_valid, i_req_vpn, d_req_valid, d_req_vpn, d_req_is_write,
    input tlb_accept, tlb_rsp_valid, tlb_phys_addr, tlb_flags,
    output i_req_ready, d_req_ready, tlb_re, tlb_addr, tlb_is_write, tlb_is_exec, tlb_user,
    output i_rsp_valid, d_rsp_valid, rsp_phys_addr, rsp_flags, err_unexp_rsp
  );
  modport master (
    output pipe_flush, user_mode, i_req_valid, i_req_vpn, d_req_valid, d_req_vpn, d_req_is_write,
    output tlb_accept, tlb_rsp_valid, tlb_phys_addr, tlb_flags,
    input i_req_ready, d_req_ready, tlb_re, tlb_addr, tlb_is_write, tlb_is_exec, tlb_user,
    input i_rsp_valid, d_rsp_valid, rsp_phys_addr, rsp_flags, err_unexp_rsp
  );
endinterface

// File: rtl/mcpu_core_tlb_owner_fifo.sv
// mcpu_core_tlb_owner_fifo: DEPTH-entry {owner,kill} FIFO; push/pop/kill_all in, full/empty/head out
module mcpu_core_tlb_owner_fifo
  import mcpu_core_tlb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       push_owner,
  input  logic       pop,
  input  logic       kill_all,
  output logic       full,
  output logic       empty,
  output owner_ent_t head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  owner_ent_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push) wr_ptr <= nxt(wr_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++)
      if (kill_all) mem[k].kill <= 1'b1;
    if (push) mem[wr_ptr] <= '{owner: push_owner, kill: 1'b0};
  end
endmodule

// File: rtl/mcpu_core_tlb_arb.sv
// mcpu_core_tlb_arb: shares one TLB lookup port between fetch (I) and data (D); clk/rst plus bus (slave modport)
module mcpu_core_tlb_arb
  import mcpu_core_tlb_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clkrst_core_clk,
  input logic clkrst_core_rst,
  mcpu_core_tlb_arb_if.slave bus
);
  logic rst, full, empty, can_issue, i_win, d_win, i_gnt, d_gnt, pop, deliver, err_q;
  logic [3:0] starve_cnt;
  owner_ent_t head;
  assign rst = clkrst_core_rst;
  assign can_issue = ~rst & ~full & ~bus.pipe_flush & bus.tlb_accept;
  assign i_win = bus.i_req_valid & (~bus.d_req_valid | starve_cnt == 4'(STARVE_LIMIT));
  assign d_win = bus.d_req_valid & ~i_win;
  assign i_gnt = can_issue & i_win;
  assign d_gnt = can_issue & d_win;
  assign pop = ~rst & bus.tlb_rsp_valid & ~empty;
  assign deliver = pop & ~head.kill & ~bus.pipe_flush;
  assign bus.i_req_ready = i_gnt;
  assign bus.d_req_ready = d_gnt;
  assign bus.tlb_re = i_gnt | d_gnt;
  assign bus.tlb_addr = i_gnt ? bus.i_req_vpn : d_gnt ? bus.d_req_vpn : '0;
  assign bus.tlb_is_write = d_gnt & bus.d_req_is_write;
  assign bus.tlb_is_exec = i_gnt;
  assign bus.tlb_user = ~rst & bus.user_mode;
  assign bus.i_rsp_valid = deliver & (head.owner == OWNER_I);
  assign bus.d_rsp_valid = deliver & (head.owner == OWNER_D);
  assign bus.rsp_phys_addr = rst ? '0 : bus.tlb_phys_addr;
  assign bus.rsp_flags = rst ? '0 : bus.tlb_flags;
  assign bus.err_unexp_rsp = ~rst & err_q;
  always_ff @(posedge clkrst_core_clk) begin
    if (rst) begin
      starve_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (bus.tlb_rsp_valid & empty);
      starve_cnt <= (~bus.i_req_valid | i_gnt) ? '0 :
                    (d_gnt & starve_cnt != 4'(STARVE_LIMIT)) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
  mcpu_core_tlb_owner_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk(clkrst_core_clk),
    .rst(rst),
    .push(i_gnt | d_gnt),
    .push_owner(d_gnt ? OWNER_D : OWNER_I),
    .pop(pop),
    .kill_all(~rst & bus.pipe_flush),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_mcpu_core_tlb_arb.sv
// tb_mcpu_core_tlb_arb: scoreboard bench with a queue-based reference model of the TLB arbiter
module tb_mcpu_core_tlb_arb;
  import mcpu_core_tlb_pkg::*;
  localparam int MO = 2;
  localparam int SL = 4;
  typedef struct { logic d; logic [19:0] addr; logic wr; logic user; } iss_t;
  typedef struct { logic d; logic [19:0] phys; logic [3:0] flags; } rsp_t;
  typedef struct { logic d; logic killed; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mcpu_core_tlb_arb_if bus();
  mcpu_core_tlb_arb #(.MAX_OUTST(MO), .STARVE_LIMIT(SL)) dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst(rst),
    .bus(bus)
  );
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  ent_t inflight[$];
  iss_t ei;
  rsp_t er;
  int dstreak = 0;
  logic m_err = 1'b0;
  logic exp_err = 1'b0;
  logic in_rst = 1'b1;
  int vec = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic r, fl, um, iv, input logic [19:0] iva, input logic dv,
                     input logic [19:0] dva, input logic dw, acc, rv, input logic [19:0] ph,
                     input logic [3:0] fg);
    logic can, want_i, gi, gd;
    ent_t h;
    @(posedge clk);
    #1;
    rst = r;
    bus.pipe_flush = fl;
    bus.user_mode = um;
    bus.i_req_valid = iv;
    bus.i_req_vpn = iva;
    bus.d_req_valid = dv;
    bus.d_req_vpn = dva;
    bus.d_req_is_write = dw;
    bus.tlb_accept = acc;
    bus.tlb_rsp_valid = rv;
    bus.tlb_phys_addr = ph;
    bus.tlb_flags = fg;
    in_rst = r;
    exp_err = r ? 1'b0 : m_err;
    if (r) begin
      inflight.delete();
      dstreak = 0;
      m_err = 1'b0;
    end else begin
      can = (inflight.size() < MO) && !fl && acc;
      want_i = iv && (!dv || dstreak >= SL);
      gi = can && want_i;
      gd = can && dv && !want_i;
      if (gi || gd) exp_iss.push_back('{gd, gd ? dva : iva, gd & dw, um});
      if (rv) begin
        if (inflight.size() == 0) m_err = 1'b1;
        else begin
          h = inflight.pop_front();
          if (!h.killed && !fl) exp_rsp.push_back('{h.d, ph, fg});
        end
      end
      if (fl) foreach (inflight[k]) inflight[k].killed = 1'b1;
      if (gi || gd) inflight.push_back('{gd, 1'b0});
      if (!iv || gi) dstreak = 0;
      else if (gd && dstreak < SL) dstreak++;
    end
  endtask
  task automatic idle(input int n, input logic rv);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, rv, 20'($urandom()), 4'($urandom()));
  endtask
  task automatic drain();
    for (int k = 0; k < 8 && inflight.size() > 0; k++) idle(1, 1);
  endtask
  initial begin
    rst = 1'b1;
    {bus.pipe_flush, bus.user_mode, bus.i_req_valid, bus.d_req_valid, bus.d_req_is_write} = '0;
    {bus.tlb_accept, bus.tlb_rsp_valid} = '0;
    bus.i_req_vpn = '0;
    bus.d_req_vpn = '0;
    bus.tlb_phys_addr = '0;
    bus.tlb_flags = '0;
  end
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tlb_re || bus.i_req_ready || bus.d_req_ready) begin
        if (exp_iss.size() == 0) chk("unexpected_issue", 64'(exp_iss.size()), 64'd1);
        else begin
          ei = exp_iss.pop_front();
          chk("tlb_re", 64'(bus.tlb_re), 64'd1);
          chk("i_req_ready", 64'(bus.i_req_ready), 64'(!ei.d));
          chk("d_req_ready", 64'(bus.d_req_ready), 64'(ei.d));
          chk("tlb_addr", 64'(bus.tlb_addr), 64'(ei.addr));
          chk("tlb_is_write", 64'(bus.tlb_is_write), 64'(ei.wr));
          chk("tlb_is_exec", 64'(bus.tlb_is_exec), 64'(!ei.d));
          chk("tlb_user", 64'(bus.tlb_user), 64'(ei.user));
        end
      end
      if (bus.i_rsp_valid || bus.d_rsp_valid) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(exp_rsp.size()), 64'd1);
        else begin
          er = exp_rsp.pop_front();
          chk("i_rsp_valid", 64'(bus.i_rsp_valid), 64'(!er.d));
          chk("d_rsp_valid", 64'(bus.d_rsp_valid), 64'(er.d));
          chk("rsp_phys_addr", 64'(bus.rsp_phys_addr), 64'(er.phys));
          chk("rsp_flags", 64'(bus.rsp_flags), 64'(er.flags));
        end
      end
      if (exp_iss.size() != 0) begin
        chk("missing_issue", 64'(exp_iss.size()), 64'd0);
        exp_iss.delete();
      end
      if (exp_rsp.size() != 0) begin
        chk("missing_rsp", 64'(exp_rsp.size()), 64'd0);
        exp_rsp.delete();
      end
      chk("err_unexp_rsp", 64'(bus.err_unexp_rsp), 64'(exp_err));
      if (in_rst)
        chk("reset_outputs_zero", {20'd0, bus.tlb_addr, bus.rsp_phys_addr, bus.rsp_flags},
            64'd0);
    end
  end
  initial begin
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 20'h00400, 0, 0, 0, 1, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 20'h12345, 4'h3);
    for (int k = 0; k < 10; k++)
      cyc(0, 0, 0, 1, 20'h01000 + 20'(k), 1, 20'h02000 + 20'(k), k[0], 1, k > 0, 20'h0a000 + 20'(k), 4'(k));
    drain();
    cyc(0, 0, 0, 0, 0, 1, 20'h03001, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 20'h03002, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 20'h03003, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 20'h03003, 0, 1, 1, 20'h0b001, 4'h1);
    cyc(0, 0, 0, 0, 0, 1, 20'h03003, 0, 1, 0, 0, 0);
    drain();
    cyc(0, 0, 0, 1, 20'h04001, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 20'h04002, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 20'h04003, 0, 1, 0, 0, 0);
    idle(2, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 20'h0dead, 4'hf);
    idle(3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);
    cyc(0, 0, 0, 1, 20'h05001, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 20'h05002, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 20'h05003, 0, 0, 0, 1, 0, 0, 0);
    drain();
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(99) == 0, $urandom_range(9) == 0, 1'($urandom()),
          $urandom_range(3) != 0, 20'($urandom()), $urandom_range(3) != 0, 20'($urandom()),
          1'($urandom()), $urandom_range(4) != 0,
          inflight.size() > 0 ? $urandom_range(1) == 1 : $urandom_range(49) == 0,
          20'($urandom()), 4'($urandom()));
    idle(1, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
